// File: rtl/lcd_display_ctrl_pkg.sv
// Shared CPU/LCD definitions: opcodes, HD44780 command bytes, display FSM states
// and small character helpers used by lcd_display_ctrl.
package cpu_defs;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_ADDI = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_SUBI = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [2:0] OP_CLR  = 3'd6;
  localparam logic [2:0] OP_DISP = 3'd7;

  localparam logic [7:0] LCD_FUNC_8B2L = 8'h38;
  localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_ENTRY_INC = 8'h06;
  localparam logic [7:0] LCD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_LINE1     = 8'h80;
  localparam logic [7:0] LCD_LINE2     = 8'hC0;

  typedef enum logic [2:0] {
    ST_PWRON,
    ST_INIT,
    ST_IDLE,
    ST_CAPTURE,
    ST_CLEAR,
    ST_LINE1,
    ST_LINE2
  } lcd_state_t;

  typedef enum logic [1:0] {
    PH_SETUP,
    PH_PULSE,
    PH_WAIT
  } byte_phase_t;

  // col 0 is the leftmost character of the 4-char space-padded mnemonic
  function automatic logic [7:0] mnem_char(input logic [2:0] op, input logic [1:0] col);
    logic [31:0] s;
    logic [4:0]  sh;
    case (op)
      OP_LOAD: s = "LOAD";
      OP_ADD:  s = "ADD ";
      OP_ADDI: s = "ADDI";
      OP_SUB:  s = "SUB ";
      OP_SUBI: s = "SUBI";
      OP_MUL:  s = "MUL ";
      OP_CLR:  s = "CLR ";
      default: s = "DISP";
    endcase
    sh = {~col, 3'b000};
    return s[sh +: 8];
  endfunction

  function automatic logic [7:0] dec_char(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/bin_to_bcd16.sv
// Sequential double-dabble: 17-bit magnitude -> 5 BCD digits in 17 shift cycles.
// done stays high from the end of a conversion until the next start.
module bin_to_bcd16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [16:0] bin,
  output logic        done,
  output logic [19:0] bcd
);

  logic [16:0] sr;
  logic [4:0]  cnt;
  logic [15:0] adj;

  // Inputs never exceed 32768, so the top digit stays below 5 and needs no adjust.
  always_comb begin
    adj = bcd[15:0];
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] > 4'd4) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr   <= '0;
      cnt  <= '0;
      done <= 1'b0;
      bcd  <= '0;
    end else if (start) begin
      sr   <= bin;
      cnt  <= 5'd17;
      done <= 1'b0;
      bcd  <= '0;
    end else if (cnt != 5'd0) begin
      bcd  <= {bcd[18:16], adj, sr[16]};
      sr   <= {sr[15:0], 1'b0};
      cnt  <= cnt - 5'd1;
      done <= (cnt == 5'd1);
    end
  end

endmodule

// File: rtl/lcd_display_ctrl.sv
// HD44780 8-bit LCD driver: power-on init, then renders "MNEM Rnn" / "+ddddd" per request.
// Define LCD_HEX_EN to append " hXXXX" (raw value in hex) to line 2.
// Handshake: a request is taken on the cycle req_valid & req_ready; req_ready/busy update next cycle.
module lcd_display_ctrl
  import cpu_defs::*;
#(
  parameter int E_PULSE_CYC    = 25,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLR_WAIT_CYC   = 100000,
  parameter int PWRON_WAIT_CYC = 750000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_opcode,
  input  logic [3:0]  req_reg,
  input  logic [15:0] req_value,
  output logic        busy,
  output logic [7:0]  lcd_data_bus,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_e,
  output logic [2:0]  dbg_state
);

  localparam int MAX_WAIT = (PWRON_WAIT_CYC > CLR_WAIT_CYC) ? PWRON_WAIT_CYC : CLR_WAIT_CYC;
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [4:0] INIT_LAST = 5'd3;
`ifdef LCD_HEX_EN
  localparam logic [4:0] REND_LAST = 5'd22;
`else
  localparam logic [4:0] REND_LAST = 5'd16;
`endif

  lcd_state_t  state;
  byte_phase_t phase;
  logic [CW-1:0] cnt;
  logic [4:0]  idx;
  logic [2:0]  op_q;
  logic [3:0]  reg_q;
  logic [15:0] val_q;
  logic [16:0] sext, mag;
  logic [3:0]  reg_lo;
  logic        bcd_start, bcd_done;
  logic [19:0] bcd_raw, bcd_q;
  logic        seq_init, engine_st, byte_end, seq_end, load;
  logic [4:0]  seq_idx, seq_last;
  lcd_state_t  nxt_state;
  logic [7:0]  nxt_data;
  logic        nxt_rs;

  assign lcd_rw    = 1'b0;
  assign dbg_state = state;
  assign bcd_start = (state == ST_CAPTURE);

  always_comb begin
    sext   = {val_q[15], val_q};
    mag    = val_q[15] ? (~sext + 17'd1) : sext;
    reg_lo = (reg_q >= 4'd10) ? (reg_q - 4'd10) : reg_q;
  end

  bin_to_bcd16 u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (bcd_start),
    .bin   (mag),
    .done  (bcd_done),
    .bcd   (bcd_raw)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bcd_q <= '0;
    else if (bcd_done) bcd_q <= bcd_raw;
  end

  // Next byte of the running sequence: index 0 when a sequence starts, else idx+1.
  always_comb begin
    seq_init  = (state == ST_PWRON) || (state == ST_INIT);
    seq_idx   = ((state == ST_PWRON) || (state == ST_CAPTURE)) ? 5'd0 : idx + 5'd1;
    seq_last  = seq_init ? INIT_LAST : REND_LAST;
    engine_st = (state == ST_INIT) || (state == ST_CLEAR) ||
                (state == ST_LINE1) || (state == ST_LINE2);
    byte_end  = engine_st && (phase == PH_WAIT) && (cnt == '0);
    seq_end   = byte_end && (idx == seq_last);
    load      = ((state == ST_PWRON) && (cnt == '0)) || (state == ST_CAPTURE) ||
                (byte_end && !seq_end);
    nxt_rs    = 1'b0;
    nxt_data  = 8'h00;
    nxt_state = ST_INIT;
    if (seq_init) begin
      case (seq_idx[1:0])
        2'd0:    nxt_data = LCD_FUNC_8B2L;
        2'd1:    nxt_data = LCD_DISP_ON;
        2'd2:    nxt_data = LCD_ENTRY_INC;
        default: nxt_data = LCD_CLEAR;
      endcase
    end else begin
      nxt_rs    = 1'b1;
      nxt_state = (seq_idx < 5'd10) ? ST_LINE1 : ST_LINE2;
      case (seq_idx)
        5'd0:  begin nxt_rs = 1'b0; nxt_state = ST_CLEAR; nxt_data = LCD_CLEAR; end
        5'd1:  begin nxt_rs = 1'b0; nxt_data = LCD_LINE1; end
        5'd2:  nxt_data = mnem_char(op_q, 2'd0);
        5'd3:  nxt_data = mnem_char(op_q, 2'd1);
        5'd4:  nxt_data = mnem_char(op_q, 2'd2);
        5'd5:  nxt_data = mnem_char(op_q, 2'd3);
        5'd6:  nxt_data = " ";
        5'd7:  nxt_data = "R";
        5'd8:  nxt_data = (reg_q >= 4'd10) ? "1" : "0";
        5'd9:  nxt_data = dec_char(reg_lo);
        5'd10: begin nxt_rs = 1'b0; nxt_data = LCD_LINE2; end
        5'd11: nxt_data = val_q[15] ? "-" : "+";
        5'd12: nxt_data = dec_char(bcd_q[19:16]);
        5'd13: nxt_data = dec_char(bcd_q[15:12]);
        5'd14: nxt_data = dec_char(bcd_q[11:8]);
        5'd15: nxt_data = dec_char(bcd_q[7:4]);
        5'd16: nxt_data = dec_char(bcd_q[3:0]);
`ifdef LCD_HEX_EN
        5'd17: nxt_data = " ";
        5'd18: nxt_data = "h";
        5'd19: nxt_data = hex_char(val_q[15:12]);
        5'd20: nxt_data = hex_char(val_q[11:8]);
        5'd21: nxt_data = hex_char(val_q[7:4]);
        5'd22: nxt_data = hex_char(val_q[3:0]);
`endif
        default: nxt_data = " ";
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_PWRON;
      phase        <= PH_SETUP;
      cnt          <= CW'(PWRON_WAIT_CYC - 1);
      idx          <= '0;
      lcd_data_bus <= '0;
      lcd_rs       <= 1'b0;
      lcd_e        <= 1'b0;
      req_ready    <= 1'b0;
      busy         <= 1'b1;
      op_q         <= '0;
      reg_q        <= '0;
      val_q        <= '0;
    end else if (load) begin
      state        <= nxt_state;
      phase        <= PH_SETUP;
      idx          <= seq_idx;
      lcd_data_bus <= nxt_data;
      lcd_rs       <= nxt_rs;
      lcd_e        <= 1'b0;
    end else if (seq_end) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_PWRON: cnt <= cnt - 1'b1;
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            op_q      <= req_opcode;
            reg_q     <= req_reg;
            val_q     <= req_value;
            state     <= ST_CAPTURE;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_CAPTURE: ;
        default: begin
          case (phase)
            PH_SETUP: begin
              lcd_e <= 1'b1;
              phase <= PH_PULSE;
              cnt   <= CW'(E_PULSE_CYC - 1);
            end
            PH_PULSE: begin
              if (cnt == '0) begin
                lcd_e <= 1'b0;
                phase <= PH_WAIT;
                cnt   <= (lcd_data_bus == LCD_CLEAR && !lcd_rs) ? CW'(CLR_WAIT_CYC - 1)
                                                                : CW'(CMD_WAIT_CYC - 1);
              end else begin
                cnt <= cnt - 1'b1;
              end
            end
            default: cnt <= cnt - 1'b1;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_display_ctrl.sv
// Bench for lcd_display_ctrl: expected LCD byte stream per request goes into exp_q,
// a negedge monitor pops one entry on every lcd_e rise and checks pulse width.
module tb_lcd_display_ctrl;

  localparam int E_CYC   = 2;
  localparam int CMD_CYC = 4;
  localparam int CLR_CYC = 8;
  localparam int PWR_CYC = 16;
`ifdef LCD_HEX_EN
  localparam int NBYTES = 23;
`else
  localparam int NBYTES = 17;
`endif
  localparam int LAT = NBYTES * (1 + E_CYC) + (NBYTES - 1) * CMD_CYC + CLR_CYC + 1;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_opcode;
  logic [3:0]  req_reg;
  logic [15:0] req_value;
  logic        busy;
  logic [7:0]  lcd_data_bus;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_e;
  logic [2:0]  dbg_state;

  logic [8:0] exp_q[$];
  int checks;
  int errors;

  lcd_display_ctrl #(
    .E_PULSE_CYC    (E_CYC),
    .CMD_WAIT_CYC   (CMD_CYC),
    .CLR_WAIT_CYC   (CLR_CYC),
    .PWRON_WAIT_CYC (PWR_CYC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_opcode   (req_opcode),
    .req_reg      (req_reg),
    .req_value    (req_value),
    .busy         (busy),
    .lcd_data_bus (lcd_data_bus),
    .lcd_rs       (lcd_rs),
    .lcd_rw       (lcd_rw),
    .lcd_e        (lcd_e),
    .dbg_state    (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: the display text built directly from the formatting rules
  task automatic push_expected(input logic [2:0] op, input logic [3:0] rg, input logic [15:0] val);
    string mn[8];
    string l1, l2;
    int sv, mag;
    mn  = '{"LOAD", "ADD ", "ADDI", "SUB ", "SUBI", "MUL ", "CLR ", "DISP"};
    sv  = int'($signed(val));
    mag = (sv < 0) ? -sv : sv;
    l1  = $sformatf("%s R%02d", mn[op], rg);
    l2  = $sformatf("%s%05d", (sv < 0) ? "-" : "+", mag);
`ifdef LCD_HEX_EN
    l2  = {l2, $sformatf(" h%04X", val)};
`endif
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < l1.len(); i++) exp_q.push_back({1'b1, l1[i]});
    exp_q.push_back({1'b0, 8'hC0});
    for (int i = 0; i < l2.len(); i++) exp_q.push_back({1'b1, l2[i]});
  endtask

  // monitor / scoreboard
  initial begin : monitor
    logic       prev_e;
    int         hi;
    logic [8:0] exp;
    prev_e = 1'b0;
    hi     = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_e = 1'b0;
        hi     = 0;
      end else begin
        if (lcd_e && !prev_e) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL byte_unexpected got rs=%0b data=%02h, required no byte", lcd_rs, lcd_data_bus);
          end else begin
            exp = exp_q.pop_front();
            if ({lcd_rs, lcd_data_bus} !== exp) begin
              errors++;
              $display("FAIL byte got rs=%0b data=%02h, required rs=%0b data=%02h",
                       lcd_rs, lcd_data_bus, exp[8], exp[7:0]);
            end
          end
          checks++;
          if (lcd_rw !== 1'b0) begin
            errors++;
            $display("FAIL lcd_rw got %0b, required 0", lcd_rw);
          end
        end
        if (lcd_e) hi++;
        else if (prev_e) begin
          checks++;
          if (hi != E_CYC) begin
            errors++;
            $display("FAIL e_width got %0d, required %0d", hi, E_CYC);
          end
          hi = 0;
        end
        prev_e = lcd_e;
      end
    end
  end

  // driver tasks
  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({lcd_data_bus, lcd_rs, lcd_rw, lcd_e, req_ready, busy} !== {8'h00, 5'b00001}) begin
      errors++;
      $display("FAIL %s got data=%02h rs=%0b rw=%0b e=%0b ready=%0b busy=%0b, required 00 0 0 0 0 1",
               tag, lcd_data_bus, lcd_rs, lcd_rw, lcd_e, req_ready, busy);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout got ready=%0b, required 1", tag, req_ready);
    end
  endtask

  task automatic check_drained(input string tag);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d pending bytes, required 0", tag, exp_q.size());
    end
  endtask

  task automatic do_init();
    int n;
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h006);
    exp_q.push_back(9'h001);
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!lcd_e && n < 200);
    checks++;
    if (n != PWR_CYC + 1) begin
      errors++;
      $display("FAIL first_e got %0d cycles, required %0d", n, PWR_CYC + 1);
    end
    wait_ready("init");
    check_drained("init");
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy got %0b, required 0", busy);
    end
  endtask

  // Called with req_ready already 1; with hold, req_valid stays high with junk during render.
  task automatic issue(input logic [2:0] op, input logic [3:0] rg, input logic [15:0] val, input bit hold);
    int n;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before got %0b, required 1", req_ready);
    end
    req_opcode = op;
    req_reg    = rg;
    req_value  = val;
    req_valid  = 1'b1;
    push_expected(op, rg, val);
    @(posedge clk);
    #1;
    checks++;
    if ({req_ready, busy} !== 2'b01) begin
      errors++;
      $display("FAIL accept got ready=%0b busy=%0b, required ready=0 busy=1", req_ready, busy);
    end
    n = 0;
    while (req_ready !== 1'b1 && n < 3000) begin
      if (hold) begin
        req_opcode = 3'($urandom);
        req_reg    = 4'($urandom);
        req_value  = 16'($urandom);
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != LAT) begin
      errors++;
      $display("FAIL latency got %0d cycles, required %0d", n, LAT);
    end
    check_drained("req");
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(0, 4)) @(posedge clk);
    #1;
  endtask

  // main sequence
  initial begin
    int n;
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_opcode = '0;
    req_reg    = '0;
    req_value  = '0;
    #3 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    do_init();

    issue(3'b001, 4'd3, 16'd42, 1'b0);
    idle_gap();
    issue(3'b111, 4'd15, 16'h8000, 1'b0);
    issue(3'b000, 4'd0, 16'h0000, 1'b0);
    idle_gap();
    issue(3'b010, 4'd10, 16'h7FFF, 1'b0);
    issue(3'b111, 4'd15, 16'hFFFF, 1'b0);

    issue(3'($urandom), 4'($urandom), 16'($urandom), 1'b1);
    issue(3'($urandom), 4'($urandom), 16'($urandom), 1'b0);

    for (int i = 0; i < 6; i++) begin
      idle_gap();
      issue(3'($urandom), 4'($urandom), 16'($urandom), 1'b0);
    end

    // reset while a data byte strobe is high mid-render
    req_opcode = 3'b101;
    req_reg    = 4'd7;
    req_value  = 16'd1234;
    req_valid  = 1'b1;
    push_expected(3'b101, 4'd7, 16'd1234);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (!(lcd_e && lcd_rs) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (!(lcd_e && lcd_rs)) begin
      errors++;
      $display("FAIL mid_render_wait got e=%0b rs=%0b, required 1 1", lcd_e, lcd_rs);
    end
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    do_init();
    issue(3'($urandom), 4'($urandom), 16'($urandom), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
